// File: rtl/mem_1024_112.sv
// mem_1024_112: 1024 x 8 read/write memory built from four 256 x 8 banks.
//   clk   : system clock, writes land on its rising edge
//   rst   : asynchronous active-low reset, clears every location
//   wEn   : write enable, active-high, sampled at posedge clk
//   addr  : word address; addr[9:8] selects the bank, addr[7:0] the word
//   din   : write data
//   dout  : combinational read data, always mem[addr]
module mem_1024_112 #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BANK_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wEn,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned OFFSET_BITS = ADDR_WIDTH - BANK_BITS;
    localparam int unsigned NUM_BANKS   = 1 << BANK_BITS;
    localparam int unsigned BANK_DEPTH  = 1 << OFFSET_BITS;

    logic [BANK_BITS-1:0]                  bank_sel;
    logic [OFFSET_BITS-1:0]                offset;
    logic [NUM_BANKS-1:0]                  bank_we;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  bank_rdata;

    // Address split into bank select and word-within-bank
    assign bank_sel = addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign offset   = addr[OFFSET_BITS-1:0];

    // One-hot bank write enable; only the addressed bank can change
    always_comb begin
        bank_we = '0;
        if (wEn) begin
            bank_we[bank_sel] = 1'b1;
        end
    end

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_q [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] mem_d [BANK_DEPTH];

        // Next-state of this bank: hold, or replace the addressed word
        always_comb begin
            mem_d = mem_q;
            if (bank_we[b]) begin
                mem_d[offset] = din;
            end
        end

        // Reset dominates any write on the same edge
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < int'(BANK_DEPTH); i++) begin
                    mem_q[i] <= '0;
                end
            end else begin
                mem_q <= mem_d;
            end
        end

        assign bank_rdata[b] = mem_q[offset];
    end

    // 4:1 read mux over the bank outputs, no output register
    assign dout = bank_rdata[bank_sel];

endmodule

// File: tb/tb_mem_1024_112.sv
// tb_mem_1024_112: directed, scoreboard-driven check of mem_1024_112.
module tb_mem_1024_112;

    logic       clk;
    logic       rst;
    logic       wEn;
    logic [9:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model [1024];
    int         total;
    int         bad;

    mem_1024_112 dut (
        .clk  (clk),
        .rst  (rst),
        .wEn  (wEn),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] a,
                         input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s addr=%0d observed=%h expected=%h", tag, a, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed=%h expected=none", tag, dout);
        end else begin
            e = sb_q.pop_front();
            check(tag, e.a, dout, e.d);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) model[i] = 8'h00;
    endtask

    // Drive at negedge, write at posedge, compare 1 ns later
    task automatic write_word(input logic [9:0] a, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        addr = a;
        din  = d;
        wEn  = 1'b1;
        if (rst) model[a] = d;
        e.a = a;
        e.d = model[a];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        sb_check("write");
    endtask

    // Combinational read away from any write
    task automatic read_check(input string tag, input logic [9:0] a);
        exp_t e;
        wEn  = 1'b0;
        addr = a;
        e.a = a;
        e.d = model[a];
        sb_q.push_back(e);
        #1;
        sb_check(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        wEn   = 1'b0;
        addr  = '0;
        din   = '0;
        model_clear();

        // Power-on reset
        #2 rst = 1'b0;
        read_check("reset_a0", 10'd0);
        read_check("reset_a1023", 10'd1023);
        #8 rst = 1'b1;

        // Sequential fill 100..120 with count
        for (int i = 0; i <= 20; i++) begin
            write_word(10'(100 + i), 8'(i));
        end
        wEn = 1'b0;

        // Read-back sweep
        for (int i = 100; i <= 120; i++) begin
            read_check("readback", 10'(i));
        end

        // Async reset mid-cycle
        @(negedge clk);
        addr = 10'd110;
        #2 rst = 1'b0;
        model_clear();
        #1;
        check("async_reset_now", addr, dout, 8'h00);
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            read_check("post_reset_sweep", 10'(i));
        end

        // Bank boundaries
        write_word(10'd255, 8'hA5);
        write_word(10'd256, 8'h5A);
        write_word(10'd0, 8'h11);
        write_word(10'd1023, 8'hFF);
        wEn = 1'b0;
        read_check("bnd_255", 10'd255);
        read_check("bnd_256", 10'd256);
        read_check("bnd_0", 10'd0);
        read_check("bnd_1023", 10'd1023);
        read_check("bnd_254", 10'd254);
        read_check("bnd_257", 10'd257);
        read_check("bnd_1", 10'd1);
        read_check("bnd_1022", 10'd1022);
        read_check("bnd_511", 10'd511);
        read_check("bnd_767", 10'd767);
        read_check("bnd_768", 10'd768);

        // Same offset in other banks must be untouched by a bank write
        write_word(10'd300, 8'h33);
        wEn = 1'b0;
        read_check("bank_iso_44", 10'd44);
        read_check("bank_iso_556", 10'd556);
        read_check("bank_iso_812", 10'd812);

        // Write-enable gating
        @(negedge clk);
        addr = 10'd300;
        din  = 8'h77;
        wEn  = 1'b0;
        @(posedge clk);
        #1;
        read_check("wen_gate_300", 10'd300);

        // Reset held across write edges
        @(negedge clk);
        #2 rst = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            write_word(10'(500 + i), 8'(8'h90 + i));
        end
        write_word(10'd255, 8'hC3);
        @(negedge clk);
        wEn = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            read_check("rst_vs_write_sweep", 10'(i));
        end

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_1024_112.md
Name: mem_1024_112

Overview:
- 1024-word x 8-bit read/write memory, for the lab datapath and for future CPU use.
- Writes are synchronous. Reads are combinational, so the addressed word is always visible on dout.
- Internally the array is four 256x8 banks. Bank select is addr[9:8]; the word within a bank is addr[7:0].
- Reset clears the whole array.

Parameters:
- ADDR_WIDTH, 10, address width; depth = 2^ADDR_WIDTH = 1024 words.
- DATA_WIDTH, 8, word width in bits.
- BANK_BITS, 2, number of high address bits used as bank select (4 banks of 256 words).

Ports:
- clk  input  1  system clock; writes occur on its rising edge.
- rst  input  1  asynchronous, active-low reset; 0 clears the entire memory.
- wEn  input  1  write enable, active-high, sampled at posedge clk.
- addr  input  10  word address, 0..1023.
- din  input  8  write data.
- dout  output  8  read data: the contents of mem[addr].

Behaviour:
- One clock; reset is asynchronous and active-low, on port rst.
- Reset:
  - When rst falls to 0, every location in all four banks becomes 8'h00 immediately, with no clock edge needed.
  - dout therefore reads 8'h00 for any address while rst = 0 and after release.
  - While rst = 0, writes are ignored; reset dominates wEn.
  - Release of rst (0->1) takes effect asynchronously. The first write can occur on the first posedge clk with rst = 1.
- Write:
  - At posedge clk with rst = 1 and wEn = 1, din is stored at bank addr[9:8], offset addr[7:0].
  - Exactly one bank is written; the other three hold their contents.
  - With wEn = 0, no location changes.
- Read:
  - dout = mem[addr] continuously, combinational, with zero clock latency.
  - A change on addr updates dout within the same cycle.
  - After a write edge, dout shows the new data at that address once the edge settles (write-then-read in the same cycle is visible after the edge).
- Bank decode:
  - One-hot bank write-enable from addr[9:8]: 00 -> bank0 (words 0-255), 01 -> bank1 (256-511), 10 -> bank2 (512-767), 11 -> bank3 (768-1023).
  - The read path is a 4:1 mux on addr[9:8] over the bank outputs.
- Boundaries:
  - Addresses 0 and 1023 are fully usable; there is no wrap or out-of-range case because the address width equals the depth.
  - Crossing a bank boundary (e.g. 255 -> 256) requires no extra cycle.
- Simultaneous events:
  - A reset asserted in the same instant as a write edge wins; the location stays 0.
  - X or Z on addr with wEn = 1 must not corrupt memory under synthesis. Simulation may propagate X.
- No internal state besides the array; there is no output register.

Test Plan:
- Sequential fill:
  - Stimulus: rst = 1, wEn = 1 held; start addr = 100, din = 0; on each negedge increment addr and set din = count; run for 21 cycles.
  - Required: sampled 1 ns after each posedge, dout equals addr - 100, i.e. R[100]=0, R[101]=1 ... R[120]=20.
- Read-back after fill:
  - Stimulus: wEn = 0; sweep addr 100..120.
  - Required: dout = addr - 100 at each address, combinationally; no location changes.
- Async reset:
  - Stimulus: after the fill, drive rst = 0 mid-cycle, away from any clock edge.
  - Required: dout = 0 immediately; after rst = 1, every address 0..1023 reads 0.
- Bank boundaries:
  - Stimulus: write 8'hA5 at 255, 8'h5A at 256, 8'h11 at 0, 8'hFF at 1023.
  - Required: each reads back its own value; neighbouring locations are unchanged.
- Write-enable gating:
  - Stimulus: wEn = 0 with din = 8'h77 at addr 300.
  - Required: mem[300] keeps its prior value.
- Reset vs write:
  - Stimulus: rst = 0 held while wEn = 1 across several clock edges.
  - Required: all locations read 0 after release.
